// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the 5-stage pipeline hazard controller:
//            opcode values, instruction field positions, the "no write"
//            writeback tag and per-opcode register-usage helpers.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Instruction field positions
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int RD_MSB = 27;
  localparam int RD_LSB = 23;
  localparam int RS_MSB = 22;
  localparam int RS_LSB = 18;
  localparam int RT_MSB = 17;
  localparam int RT_LSB = 13;

  // Opcodes; 10..15 decode as NOP
  localparam logic [3:0] ALU_LW    = 4'd0;
  localparam logic [3:0] ALU_SW    = 4'd1;
  localparam logic [3:0] ALU_LI    = 4'd2;
  localparam logic [3:0] ALU_ADDU  = 4'd3;
  localparam logic [3:0] ALU_ADDIU = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_MUL   = 4'd6;
  localparam logic [3:0] ALU_BGE   = 4'd7;
  localparam logic [3:0] ALU_J     = 4'd8;
  localparam logic [3:0] ALU_MULI  = 4'd9;

  // Writeback tag carrying no register write (bit 5 clear)
  localparam logic [5:0] NO_WRITE_TAG = 6'b011111;

  // Opcode writes rd
  function automatic logic is_writer(input logic [3:0] op);
    return (op == ALU_LW)   || (op == ALU_LI)    || (op == ALU_ADDU) ||
           (op == ALU_ADDIU)|| (op == ALU_SLL)   || (op == ALU_MUL)  ||
           (op == ALU_MULI);
  endfunction

  // Opcode reads rs
  function automatic logic uses_rs(input logic [3:0] op);
    return (op == ALU_LW)   || (op == ALU_SW)    || (op == ALU_ADDU) ||
           (op == ALU_ADDIU)|| (op == ALU_SLL)   || (op == ALU_MUL)  ||
           (op == ALU_BGE)  || (op == ALU_MULI);
  endfunction

  // Opcode reads rt
  function automatic logic uses_rt(input logic [3:0] op);
    return (op == ALU_ADDU) || (op == ALU_MUL);
  endfunction

  // Opcode reads the rd field as a source (store data, branch compare)
  function automatic logic uses_rd_src(input logic [3:0] op);
    return (op == ALU_SW) || (op == ALU_BGE);
  endfunction

  // Opcode occupies the multi-cycle multiplier
  function automatic logic is_mul(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hz_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hz_scoreboard
// Purpose  : Register scoreboard of outstanding writes. One set port (issue)
//            and one clear port (writeback) per cycle; when both target the
//            same register the set wins, because the newly issued writer is
//            still outstanding.
// Ports    : clk_i      - clock
//            rst_i      - synchronous active-high reset (clears all bits)
//            i_set_en   - mark register i_set_idx outstanding
//            i_set_idx  - register to mark
//            i_clr_en   - retire register i_clr_idx
//            i_clr_idx  - register to retire
//            o_pending  - registered scoreboard, bit r = write to r in flight
// Revision : 1.0 - initial release
// ============================================================================
module hz_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            i_set_en,
  input  logic [4:0]      i_set_idx,
  input  logic            i_clr_en,
  input  logic [4:0]      i_clr_idx,
  output logic [NREG-1:0] o_pending
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
  end

  // Clear first, then OR in the set: set-wins on a same-register collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_pending <= '0;
    else       r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Issue/interlock controller beside the decode stage. Stalls the
//            ID instruction on RAW/WAW hazards against the scoreboard and
//            while the multiplier occupies EX; flushes on a taken branch.
//            All decisions are combinational from registered state + inputs.
// Ports    : clk_i        - clock
//            rst_i        - synchronous active-high reset
//            id_IR_i      - instruction in ID
//            id_valid_i   - id_IR_i is a real instruction
//            br_taken_i   - EX resolved a taken BGE/J this cycle
//            wb_reg_num_i - writeback tag {valid, reg}
//            issue_o      - ID instruction advances to EX
//            stall_o      - hold PC/IF-ID, bubble into EX
//            flush_o      - squash IF/ID
//            mul_busy_o   - multiplier occupies EX
//            pending_o    - scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int NREG    = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     id_IR_i,
  input  logic            id_valid_i,
  input  logic            br_taken_i,
  input  logic [5:0]      wb_reg_num_i,
  output logic            issue_o,
  output logic            stall_o,
  output logic            flush_o,
  output logic            mul_busy_o,
  output logic [NREG-1:0] pending_o
);

  localparam int                 c_CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic [3:0]         w_op;
  logic [4:0]         w_rd;
  logic [4:0]         w_rs;
  logic [4:0]         w_rt;
  logic               w_hazard;
  logic               w_set_en;
  logic [NREG-1:0]    w_pending;
  logic [c_CNT_W-1:0] r_mul_cnt;
  logic               w_unused_ir;

  assign w_op = id_IR_i[OP_MSB:OP_LSB];
  assign w_rd = id_IR_i[RD_MSB:RD_LSB];
  assign w_rs = id_IR_i[RS_MSB:RS_LSB];
  assign w_rt = id_IR_i[RT_MSB:RT_LSB];

  // Immediate/offset bits carry no register numbers.
  assign w_unused_ir = ^id_IR_i[RT_LSB-1:0];

  // Checked against the registered scoreboard only: a writeback in this
  // cycle is not bypassed, so the consumer issues one cycle after the tag.
  assign w_hazard = id_valid_i &
                    ((uses_rs(w_op)     & w_pending[w_rs]) |
                     (uses_rt(w_op)     & w_pending[w_rt]) |
                     (uses_rd_src(w_op) & w_pending[w_rd]) |
                     (is_writer(w_op)   & w_pending[w_rd]));

  // Flush dominates: a squashed instruction neither stalls nor issues.
  assign flush_o    = br_taken_i;
  assign mul_busy_o = (r_mul_cnt != '0);
  assign stall_o    = ~flush_o & id_valid_i & (w_hazard | mul_busy_o);
  assign issue_o    = id_valid_i & ~stall_o & ~flush_o;

  assign w_set_en = issue_o & is_writer(w_op);

  hz_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_set_en  (w_set_en),
    .i_set_idx (w_rd),
    .i_clr_en  (wb_reg_num_i[5]),
    .i_clr_idx (wb_reg_num_i[4:0]),
    .o_pending (w_pending)
  );

  // Remaining EX occupancy of the multiplier after its issue cycle. Keeps
  // counting through a flush since the older multiply still completes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mul_cnt <= '0;
    end else if (issue_o & is_mul(w_op)) begin
      r_mul_cnt <= c_MUL_LOAD;
    end else if (r_mul_cnt != '0) begin
      r_mul_cnt <= r_mul_cnt - c_CNT_ONE;
    end
  end

  assign pending_o = w_pending;

endmodule
`default_nettype wire
